traffic_phase_arbiter: RTL and testbench

- Four-approach intersection signal scheduler. Approaches are A–D, indexed 0–3.
- Grants green to one approach at a time. Selection is round-robin among approaches with a pending vehicle request.
- Inserts yellow and all-red clearance between greens, serves latched pedestrian requests with an all-stop walk phase, and supports emergency preemption.
- Drives the per-approach lamp-code LED encoder, the walk/stop dot-matrix selector, and the remaining-time FND.

---
 rtl/traffic_phase_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_traffic_phase_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_arbiter.sv
// Four-approach intersection scheduler: round-robin green with yellow/all-red
// clearance, latched pedestrian walk phase and emergency preemption.
module traffic_phase_arbiter #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned MAX_GREEN = 20,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned PED_T     = 10
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Req,
  input  logic       i_Ped,
  input  logic       i_Emg,
  input  logic [1:0] i_EmgDir,
  output logic [3:0] o_Green,
  output logic [3:0] o_Yellow,
  output logic       o_AllRed,
  output logic       o_PedWalk,
  output logic [1:0] o_Phase,
  output logic [7:0] o_Remain
);

  localparam int unsigned   DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [7:0]    MIN_G    = 8'(MIN_GREEN);
  localparam logic [7:0]    MAX_G    = 8'(MAX_GREEN);
  localparam logic [7:0]    YEL_L    = 8'(YELLOW_T);
  localparam logic [7:0]    AR_L     = 8'(ALLRED_T);
  localparam logic [7:0]    PED_L    = 8'(PED_T);

  typedef enum logic [2:0] {
    S_GREEN,
    S_YELLOW,
    S_ALLRED,
    S_PED,
    S_EMG
  } state_t;

  state_t        state, state_n;
  logic [1:0]    cur, cur_n, nxt_dir;
  logic [7:0]    g_cnt, g_cnt_n, g_inc, g_eff;
  logic [7:0]    remain, remain_n;
  logic [DW-1:0] div;
  logic          ped_q, ped_pend, ped_pend_n;
  logic          tick, enter, timed_done;
  logic [3:0]    cur_oh;
  logic          other, own, ped_edge, green_exit;

  assign tick       = (div == DIV_LAST);
  assign timed_done = tick && (remain == 8'd1);
  assign cur_oh     = 4'b0001 << cur;
  assign other      = |(i_Req & ~cur_oh);
  assign own        = i_Req[cur];
  assign ped_edge   = i_Ped & ~ped_q;
  assign g_inc      = (g_cnt >= MAX_G) ? MAX_G : g_cnt + 8'd1;
  // Exit is judged against the count this tick produces, so a green of N
  // ticks lasts exactly N*TICK_DIV cycles rather than one cycle longer.
  assign g_eff      = tick ? g_inc : g_cnt;
  assign green_exit = (other || ped_pend) && (g_eff >= MIN_G) &&
                      (!own || (g_eff >= MAX_G));

  // Iterating downward lets the nearest requesting approach win.
  always_comb begin
    nxt_dir = cur + 2'd1;
    for (int unsigned k = 4; k >= 1; k--) begin
      if (i_Req[cur + 2'(k)]) nxt_dir = cur + 2'(k);
    end
  end

  always_comb begin
    state_n  = state;
    cur_n    = cur;
    g_cnt_n  = g_cnt;
    remain_n = remain;
    enter    = 1'b0;
    unique case (state)
      S_GREEN: begin
        g_cnt_n = g_eff;
        if (i_Emg && (i_EmgDir == cur)) begin
          state_n  = S_EMG;
          remain_n = '0;
          enter    = 1'b1;
        end else if (i_Emg || green_exit) begin
          state_n  = S_YELLOW;
          remain_n = YEL_L;
          enter    = 1'b1;
        end
      end
      S_YELLOW: begin
        if (timed_done) begin
          state_n  = S_ALLRED;
          remain_n = AR_L;
          enter    = 1'b1;
        end else if (tick) begin
          remain_n = remain - 8'd1;
        end
      end
      S_ALLRED: begin
        if (timed_done) begin
          enter = 1'b1;
          if (i_Emg) begin
            state_n  = S_EMG;
            cur_n    = i_EmgDir;
            remain_n = '0;
          end else if (ped_pend) begin
            state_n  = S_PED;
            remain_n = PED_L;
          end else begin
            state_n = S_GREEN;
            cur_n   = nxt_dir;
            g_cnt_n = '0;
          end
        end else if (tick) begin
          remain_n = remain - 8'd1;
        end
      end
      S_PED: begin
        if (i_Emg) begin
          state_n  = S_ALLRED;
          remain_n = AR_L;
          enter    = 1'b1;
        end else if (timed_done) begin
          state_n = S_GREEN;
          cur_n   = nxt_dir;
          g_cnt_n = '0;
          enter   = 1'b1;
        end else if (tick) begin
          remain_n = remain - 8'd1;
        end
      end
      S_EMG: begin
        if (!i_Emg) begin
          state_n  = S_YELLOW;
          remain_n = YEL_L;
          enter    = 1'b1;
        end
      end
      default: begin
        state_n = S_GREEN;
        enter   = 1'b1;
      end
    endcase
  end

  always_comb begin
    ped_pend_n = ped_pend;
    if (state_n == S_PED && state != S_PED) ped_pend_n = 1'b0;
    else if (ped_edge && state != S_PED)    ped_pend_n = 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state    <= S_GREEN;
      cur      <= '0;
      g_cnt    <= '0;
      remain   <= '0;
      div      <= '0;
      ped_q    <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      state    <= state_n;
      cur      <= cur_n;
      g_cnt    <= g_cnt_n;
      remain   <= remain_n;
      div      <= (enter || tick) ? '0 : div + DW'(1);
      ped_q    <= i_Ped;
      ped_pend <= ped_pend_n;
    end
  end

  always_comb begin
    o_Green   = '0;
    o_Yellow  = '0;
    o_AllRed  = 1'b0;
    o_PedWalk = 1'b0;
    o_Phase   = cur;
    o_Remain  = remain;
    unique case (state)
      S_GREEN: begin
        o_Green  = cur_oh;
        o_Remain = MAX_G - g_cnt;
      end
      S_YELLOW: o_Yellow = cur_oh;
      S_ALLRED: o_AllRed = 1'b1;
      S_PED: begin
        o_AllRed  = 1'b1;
        o_PedWalk = 1'b1;
      end
      S_EMG: begin
        o_Green  = cur_oh;
        o_Remain = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Directed bench for traffic_phase_arbiter at a short tick so every phase
// boundary can be checked at an exact cycle.
module tb_traffic_phase_arbiter;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b0;
  logic [3:0] i_Req = '0;
  logic       i_Ped = 1'b0;
  logic       i_Emg = 1'b0;
  logic [1:0] i_EmgDir = '0;
  logic [3:0] o_Green, o_Yellow;
  logic       o_AllRed, o_PedWalk;
  logic [1:0] o_Phase;
  logic [7:0] o_Remain;

  int unsigned cyc      = 0;
  int unsigned n_pass   = 0;
  int unsigned n_checks = 0;

  traffic_phase_arbiter #(
    .TICK_DIV (4),
    .MIN_GREEN(2),
    .MAX_GREEN(4),
    .YELLOW_T (2),
    .ALLRED_T (1),
    .PED_T    (3)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Req    (i_Req),
    .i_Ped    (i_Ped),
    .i_Emg    (i_Emg),
    .i_EmgDir (i_EmgDir),
    .o_Green  (o_Green),
    .o_Yellow (o_Yellow),
    .o_AllRed (o_AllRed),
    .o_PedWalk(o_PedWalk),
    .o_Phase  (o_Phase),
    .o_Remain (o_Remain)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic step();
    @(posedge i_Clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int unsigned n);
    while (cyc < n) step();
  endtask

  // Cycle 0 is the first cycle after release; inputs set at cycle k are
  // sampled by the edge that ends cycle k.
  task automatic do_reset();
    i_Rst = 1'b0;
    repeat (3) step();
    i_Rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    // 1: idle rest on green A
    do_reset();
    check("rst_green",  8'(o_Green), 8'h01);
    check("rst_yellow", 8'(o_Yellow), 8'h00);
    check("rst_allred", 8'(o_AllRed), 8'h00);
    check("rst_walk",   8'(o_PedWalk), 8'h00);
    check("rst_phase",  8'(o_Phase), 8'h00);
    check("rst_remain", o_Remain, 8'd4);
    run_to(4);
    check("idle_remain4", o_Remain, 8'd3);
    run_to(200);
    check("idle_green",  8'(o_Green), 8'h01);
    check("idle_remain", o_Remain, 8'd0);

    // 2: request on C only
    i_Req = 4'b0100;
    do_reset();
    run_to(7);
    check("c_green7",   8'(o_Green), 8'h01);
    run_to(8);
    check("c_yel8",     8'(o_Yellow), 8'h01);
    check("c_rem8",     o_Remain, 8'd2);
    run_to(12);
    check("c_rem12",    o_Remain, 8'd1);
    run_to(15);
    check("c_yel15",    8'(o_Yellow), 8'h01);
    run_to(16);
    check("c_ar16",     8'(o_AllRed), 8'h01);
    check("c_yel16",    8'(o_Yellow), 8'h00);
    run_to(19);
    check("c_ar19",     8'(o_AllRed), 8'h01);
    run_to(20);
    check("c_green20",  8'(o_Green), 8'h04);
    check("c_phase20",  8'(o_Phase), 8'h02);

    // 3: own request held forces max extension
    i_Req = 4'b0011;
    do_reset();
    run_to(15);
    check("ab_green15", 8'(o_Green), 8'h01);
    check("ab_rem15",   o_Remain, 8'd1);
    run_to(16);
    check("ab_yel16",   8'(o_Yellow), 8'h01);
    run_to(23);
    check("ab_yel23",   8'(o_Yellow), 8'h01);
    run_to(24);
    check("ab_ar24",    8'(o_AllRed), 8'h01);
    run_to(28);
    check("ab_green28", 8'(o_Green), 8'h02);
    check("ab_phase28", 8'(o_Phase), 8'h01);

    // 4: pedestrian walk, second press during walk is dropped
    i_Req = 4'b0000;
    do_reset();
    run_to(2); i_Ped = 1'b1;
    step();    i_Ped = 1'b0;
    run_to(7);
    check("p_green7",   8'(o_Green), 8'h01);
    run_to(8);
    check("p_yel8",     8'(o_Yellow), 8'h01);
    run_to(19);
    check("p_ar19",     8'(o_AllRed), 8'h01);
    check("p_walk19",   8'(o_PedWalk), 8'h00);
    run_to(20);
    check("p_walk20",   8'(o_PedWalk), 8'h01);
    check("p_ar20",     8'(o_AllRed), 8'h01);
    check("p_rem20",    o_Remain, 8'd3);
    run_to(24); i_Ped = 1'b1;
    check("p_rem24",    o_Remain, 8'd2);
    step();     i_Ped = 1'b0;
    run_to(31);
    check("p_walk31",   8'(o_PedWalk), 8'h01);
    run_to(32);
    check("p_walk32",   8'(o_PedWalk), 8'h00);
    check("p_green32",  8'(o_Green), 8'h02);
    check("p_phase32",  8'(o_Phase), 8'h01);
    run_to(72);
    check("p_rest72",   8'(o_Green), 8'h02);
    check("p_noyel72",  8'(o_Yellow), 8'h00);

    // 5: preemption to D, MIN_GREEN ignored
    do_reset();
    run_to(1); i_Emg = 1'b1; i_EmgDir = 2'd3;
    check("e_green1",   8'(o_Green), 8'h01);
    step();
    check("e_yel2",     8'(o_Yellow), 8'h01);
    run_to(9);
    check("e_yel9",     8'(o_Yellow), 8'h01);
    run_to(10);
    check("e_ar10",     8'(o_AllRed), 8'h01);
    run_to(13);
    check("e_ar13",     8'(o_AllRed), 8'h01);
    run_to(14);
    check("e_green14",  8'(o_Green), 8'h08);
    check("e_phase14",  8'(o_Phase), 8'h03);
    check("e_rem14",    o_Remain, 8'd0);
    run_to(20); i_EmgDir = 2'd1;
    run_to(25);
    check("e_hold25",   8'(o_Green), 8'h08);
    run_to(30); i_Emg = 1'b0;
    step();
    check("e_yel31",    8'(o_Yellow), 8'h08);
    check("e_rem31",    o_Remain, 8'd2);
    run_to(38);
    check("e_yel38",    8'(o_Yellow), 8'h08);
    run_to(39);
    check("e_ar39",     8'(o_AllRed), 8'h01);
    run_to(43);
    check("e_green43",  8'(o_Green), 8'h01);
    check("e_phase43",  8'(o_Phase), 8'h00);

    // 5b: preemption toward the current approach goes straight to EMG
    i_EmgDir = 2'd0;
    do_reset();
    run_to(1); i_Emg = 1'b1;
    step();
    check("es_green2",  8'(o_Green), 8'h01);
    check("es_rem2",    o_Remain, 8'd0);
    run_to(5); i_Emg = 1'b0;
    step();
    check("es_yel6",    8'(o_Yellow), 8'h01);

    // 5c: preemption aborts the walk into a full all-red
    do_reset();
    run_to(2); i_Ped = 1'b1;
    step();    i_Ped = 1'b0;
    run_to(22);
    check("pa_walk22",  8'(o_PedWalk), 8'h01);
    i_Emg = 1'b1; i_EmgDir = 2'd2;
    step();
    check("pa_walk23",  8'(o_PedWalk), 8'h00);
    check("pa_ar23",    8'(o_AllRed), 8'h01);
    run_to(26);
    check("pa_ar26",    8'(o_AllRed), 8'h01);
    run_to(27);
    check("pa_green27", 8'(o_Green), 8'h04);
    check("pa_phase27", 8'(o_Phase), 8'h02);
    i_Emg = 1'b0;

    // 6: reset mid-yellow clears the pedestrian latch
    do_reset();
    run_to(2); i_Ped = 1'b1;
    step();    i_Ped = 1'b0;
    run_to(10);
    check("r_yel10",    8'(o_Yellow), 8'h01);
    i_Rst = 1'b0;
    step();
    i_Rst = 1'b1;
    check("r_green",    8'(o_Green), 8'h01);
    check("r_yel",      8'(o_Yellow), 8'h00);
    check("r_remain",   o_Remain, 8'd4);
    cyc = 0;
    run_to(40);
    check("r_rest40",   8'(o_Green), 8'h01);
    check("r_noyel40",  8'(o_Yellow), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
